modadd_serial: RTL and testbench

//  Sequential modular adder: o = (x + y) mod n for operands already reduced (x<n, y<n).
//  The addition-side companion to the combinational 64-bit subtractor.

---
 rtl/modadd_serial_pkg.sv | 20 ++
 rtl/modadd_serial_digit_addsub.sv | 39 +++
 rtl/modadd_serial.sv | 152 +++++++++++++++
 tb/tb_modadd_serial.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/modadd_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : modadd_serial_pkg
//  Purpose  : Shared RSA datapath constants for the digit-serial modular adder.
//             Holds the default operand/digit widths and the 2-bit state
//             encodings used by the adder FSM.
//  Revision : 1.0  initial release
// ============================================================================
package modadd_serial_pkg;

    localparam int c_rsa_width = 64;
    localparam int c_rsa_digit = 16;

    localparam logic [1:0] c_ma_idle = 2'b00;
    localparam logic [1:0] c_ma_add  = 2'b01;
    localparam logic [1:0] c_ma_sub  = 2'b10;
    localparam logic [1:0] c_ma_done = 2'b11;

endpackage
`default_nettype wire

// File: rtl/modadd_serial_digit_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : modadd_serial_digit_addsub
//  Purpose  : One DIGIT-wide adder/subtractor slice shared by both passes
//             of the serial modular adder.
//  Ports    : a, b  - digit operands
//             cin   - carry in (sub=0) or borrow in (sub=1)
//             sub   - 0: r = a + b + cin, 1: r = a - b - cin
//             r     - digit result
//             cout  - carry out (sub=0) or borrow out (sub=1)
//  Revision : 1.0  initial release
// ============================================================================
module modadd_serial_digit_addsub #(
    parameter int DIGIT = 16
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [DIGIT-1:0] r,
    output logic             cout
);

    logic [DIGIT:0] w_ext;

    // Evaluated one bit wider than the digit: for the subtract case the top
    // bit of the wrapped difference is set exactly when a - b - cin < 0.
    always_comb begin
        w_ext = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
        if (sub) begin
            w_ext = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, cin};
        end
    end

    assign r    = w_ext[DIGIT-1:0];
    assign cout = w_ext[DIGIT];

endmodule
`default_nettype wire

// File: rtl/modadd_serial.sv
`default_nettype none
// ============================================================================
//  Module   : modadd_serial
//  Purpose  : Digit-serial modular adder, o = (x + y) mod n for x, y < n.
//             K = WIDTH/DIGIT add cycles build S and carry C, then K
//             subtract cycles build D = S - n and borrow b. The result is
//             D when {C,S} >= n (C==1 or b==0), otherwise S.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             start        - request, accepted in IDLE or DONE only
//             x, y, n      - addends and modulus
//             busy         - high during ADD and SUB
//             done         - one-cycle pulse, o valid from this cycle
//             o            - result, held until the next completion
//  Revision : 1.0  initial release
// ============================================================================
module modadd_serial
    import modadd_serial_pkg::*;
#(
    parameter int WIDTH = c_rsa_width,
    parameter int DIGIT = c_rsa_digit
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o
);

    localparam int c_k  = WIDTH / DIGIT;
    localparam int c_cw = (c_k > 1) ? $clog2(c_k) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_k - 1);

    logic [1:0]       r_state;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_x, r_y, r_n;
    logic [WIDTH-1:0] r_s, r_d, r_o;
    logic             r_c, r_b;
    logic             r_busy, r_done;

    logic [DIGIT-1:0] w_opa, w_opb, w_r;
    logic             w_cin, w_sub, w_cout;
    logic [WIDTH-1:0] w_s_shift, w_s_rot, w_d_shift;

    // The single slice is steered by state: x/y/carry in ADD, S/n/borrow in SUB.
    always_comb begin
        w_opa = r_x[DIGIT-1:0];
        w_opb = r_y[DIGIT-1:0];
        w_cin = r_c;
        w_sub = 1'b0;
        if (r_state == c_ma_sub) begin
            w_opa = r_s[DIGIT-1:0];
            w_opb = r_n[DIGIT-1:0];
            w_cin = r_b;
            w_sub = 1'b1;
        end
    end

    modadd_serial_digit_addsub #(
        .DIGIT (DIGIT)
    ) u_addsub (
        .a    (w_opa),
        .b    (w_opb),
        .cin  (w_cin),
        .sub  (w_sub),
        .r    (w_r),
        .cout (w_cout)
    );

    // New digits enter at the top so the word is LSB-aligned after K shifts.
    assign w_s_shift = WIDTH'({w_r, r_s} >> DIGIT);
    assign w_d_shift = WIDTH'({w_r, r_d} >> DIGIT);
    // S is rotated during SUB so it is intact again when the result is chosen.
    assign w_s_rot   = {r_s[DIGIT-1:0], r_s[WIDTH-1:DIGIT]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ma_idle;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_n     <= '0;
            r_s     <= '0;
            r_d     <= '0;
            r_o     <= '0;
            r_c     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ma_idle, c_ma_done: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_n     <= n;
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ma_add;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_ma_idle;
                    end
                end
                c_ma_add: begin
                    r_x <= r_x >> DIGIT;
                    r_y <= r_y >> DIGIT;
                    r_s <= w_s_shift;
                    r_c <= w_cout;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_b     <= 1'b0;
                        r_state <= c_ma_sub;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ma_sub: begin
                    r_n <= r_n >> DIGIT;
                    r_s <= w_s_rot;
                    r_d <= w_d_shift;
                    r_b <= w_cout;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ma_done;
                        // {C,S} >= n exactly when the sum carried out or the
                        // full-width subtraction did not borrow.
                        r_o     <= (r_c || !w_cout) ? w_d_shift : w_s_rot;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ma_idle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign o    = r_o;

endmodule
`default_nettype wire

// File: tb/tb_modadd_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_modadd_serial
//  Purpose  : Scoreboard bench for modadd_serial at WIDTH=64, DIGIT=16.
//             Stimulus pushes the hand-computed result and its start edge;
//             the monitor pops on every done pulse and checks value/latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_modadd_serial;

    typedef struct {
        logic [63:0] o;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] x = '0, y = '0, n = '0;
    logic        busy, done;
    logic [63:0] o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_done_cyc = 0;
    bit   prev_done = 1'b0;
    exp_t sb[$];

    modadd_serial #(.WIDTH(64), .DIGIT(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .o     (o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            last_done_cyc = cyc;
            if (prev_done) check("done_single_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", o, e.o);
                check("latency", 64'(cyc - e.cyc), 64'd8);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                         input bit track, input logic [63:0] e);
        exp_t it;
        @(negedge clk);
        x = a; y = b; n = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            it.o = e; it.cyc = cyc;
            sb.push_back(it);
        end
    endtask

    // Stops at the negedge where done is seen; counts busy cycles before it.
    task automatic wait_done(output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int bc;
        int t1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_o", o, 64'd0);

        // 1: basic reduction, with busy duration
        issue(64'd5, 64'd7, 64'd11, 1'b1, 64'd1);
        wait_done(bc);
        check("busy_cycles", 64'(bc), 64'd8);
        @(negedge clk);
        check("done_dropped", 64'(done), 64'd0);

        // 2: no-subtract path
        issue(64'd3, 64'd4, 64'd100, 1'b1, 64'd7);
        wait_done(bc);

        // 3: carry out of the full-width sum
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
              1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done(bc);

        // 4: sum equal to modulus
        issue(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              1'b1, 64'd0);
        wait_done(bc);

        // 5: reset mid-operation, then a clean operation
        issue(64'd9, 64'd9, 64'd10, 1'b0, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_o", o, 64'd0);
        repeat (12) @(negedge clk);
        check("abort_o_later", o, 64'd0);
        issue(64'd1, 64'd2, 64'd5, 1'b1, 64'd3);
        wait_done(bc);

        // 6a: start during ADD with different operands is ignored
        issue(64'd5, 64'd7, 64'd11, 1'b1, 64'd1);
        @(negedge clk);
        @(negedge clk);
        x = 64'd3; y = 64'd4; n = 64'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(bc);

        // 6b: start presented in DONE is accepted back-to-back
        issue(64'd3, 64'd4, 64'd100, 1'b1, 64'd7);
        wait_done(bc);
        t1 = cyc;
        x = 64'd5; y = 64'd7; n = 64'd11; start = 1'b1;
        @(posedge clk);
        #1 begin
            exp_t it;
            start = 1'b0;
            it.o = 64'd1; it.cyc = cyc;
            sb.push_back(it);
        end
        wait_done(bc);
        check("b2b_spacing", 64'(cyc - t1), 64'd9);

        // drain the scoreboard with a bound
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
